// File: rtl/ai_sram_arbiter_pkg.sv
// Shared constants for the multi-client SRAM arbiter: fixed channel ids and
// helpers that size the channel-id and burst-counter fields.
package ai_sram_arbiter_pkg;

    localparam int CH_WB    = 0;
    localparam int CH_MMUL  = 1;
    localparam int CH_MCONV = 2;

    function automatic int ch_id_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int burst_cnt_w(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/ai_rr_picker.sv
// Combinational round-robin picker: grants the first eligible requester
// after the pointer, wrapping modulo NUM_CH.
module ai_rr_picker
    import ai_sram_arbiter_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int IDW    = ch_id_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDW-1:0]    ptr,
    input  logic [NUM_CH-1:0] excl,
    output logic [NUM_CH-1:0] gnt,
    output logic [IDW-1:0]    id
);

    logic [NUM_CH-1:0] cand;

    assign cand = req & ~excl;

    always_comb begin
        logic           found;
        logic [IDW-1:0] idx;
        gnt   = '0;
        id    = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = IDW'((int'(ptr) + i) % NUM_CH);
            if (!found && cand[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                id       = idx;
            end
        end
    end

endmodule

// File: rtl/ai_sram_arbiter.sv
// Arbitrates NUM_CH requesters onto one single-port SRAM; reads return after a
// fixed latency, steered back to the issuing channel by a tag pipeline.
module ai_sram_arbiter
    import ai_sram_arbiter_pkg::*;
#(
    parameter int NUM_CH    = 3,
    parameter int AW        = 8,
    parameter int DW        = 32,
    parameter int RD_LAT    = 1,
    parameter int CH0_PRIO  = 1,
    parameter int MAX_BURST = 16
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_ni,
    input  logic [NUM_CH-1:0]      ch_req_i,
    input  logic [NUM_CH-1:0]      ch_lock_i,
    input  logic [NUM_CH-1:0]      ch_we_i,
    input  logic [NUM_CH*DW/8-1:0] ch_be_i,
    input  logic [NUM_CH*AW-1:0]   ch_addr_i,
    input  logic [NUM_CH*DW-1:0]   ch_wdata_i,
    output logic [NUM_CH-1:0]      ch_gnt_o,
    output logic [NUM_CH-1:0]      ch_rvalid_o,
    output logic [DW-1:0]          ch_rdata_o,
    output logic                   sram_en_o,
    output logic [DW/8-1:0]        sram_we_o,
    output logic [AW-1:0]          sram_addr_o,
    output logic [DW-1:0]          sram_wdata_o,
    input  logic [DW-1:0]          sram_rdata_i,
    output logic                   busy_o
);

    localparam int BW  = DW / 8;
    localparam int IDW = ch_id_w(NUM_CH);
    localparam int CW  = burst_cnt_w(MAX_BURST);

    logic [IDW-1:0]    rr_ptr;
    logic              owner_vld;
    logic [IDW-1:0]    owner_id;
    logic [CW-1:0]     burst_cnt;

    logic [NUM_CH-1:0] owner_oh;
    logic              cap_hit;
    logic              hold;
    logic [NUM_CH-1:0] excl;
    logic [NUM_CH-1:0] rr_gnt;
    logic [IDW-1:0]    rr_id;
    logic [NUM_CH-1:0] gnt;
    logic [IDW-1:0]    gid;
    logic              any_gnt;

    logic              sel_we;
    logic [BW-1:0]     sel_be;
    logic [AW-1:0]     sel_addr;
    logic [DW-1:0]     sel_wdata;

    logic              tag_vld [0:RD_LAT];
    logic [IDW-1:0]    tag_id  [0:RD_LAT];
    logic              tag_any;

    assign owner_oh = owner_vld ? (NUM_CH'(1) << owner_id) : '0;
    assign cap_hit  = owner_vld && (burst_cnt >= CW'(MAX_BURST));
    assign hold     = owner_vld && !cap_hit && |(ch_req_i & ch_lock_i & owner_oh);
    // A capped owner steps aside only when someone else is waiting.
    assign excl     = (cap_hit && |(ch_req_i & ~owner_oh)) ? owner_oh : '0;

    ai_rr_picker #(
        .NUM_CH (NUM_CH),
        .IDW    (IDW)
    ) u_picker (
        .req  (ch_req_i),
        .ptr  (rr_ptr),
        .excl (excl),
        .gnt  (rr_gnt),
        .id   (rr_id)
    );

    always_comb begin
        gnt = rr_gnt;
        gid = rr_id;
        if (hold) begin
            gnt = owner_oh;
            gid = owner_id;
        end else if ((CH0_PRIO != 0) && ch_req_i[CH_WB] && !excl[CH_WB]) begin
            gnt = NUM_CH'(1) << CH_WB;
            gid = IDW'(CH_WB);
        end
    end

    assign any_gnt  = |gnt;
    assign ch_gnt_o = wb_rst_ni ? gnt : '0;

    assign sel_we    = ch_we_i[gid];
    assign sel_be    = ch_be_i[int'(gid)*BW +: BW];
    assign sel_addr  = ch_addr_i[int'(gid)*AW +: AW];
    assign sel_wdata = ch_wdata_i[int'(gid)*DW +: DW];

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            rr_ptr    <= IDW'(NUM_CH - 1);
            owner_vld <= 1'b0;
            owner_id  <= '0;
            burst_cnt <= '0;
        end else if (any_gnt) begin
            rr_ptr    <= gid;
            owner_vld <= ch_lock_i[gid];
            owner_id  <= gid;
            burst_cnt <= (owner_vld && (gid == owner_id) && !cap_hit) ? burst_cnt + 1'b1 : CW'(1);
        end else begin
            owner_vld <= 1'b0;
            burst_cnt <= '0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sram_en_o    <= 1'b0;
            sram_we_o    <= '0;
            sram_addr_o  <= '0;
            sram_wdata_o <= '0;
        end else begin
            sram_en_o <= any_gnt;
            sram_we_o <= (any_gnt && sel_we) ? sel_be : '0;
            if (any_gnt) begin
                sram_addr_o  <= sel_addr;
                sram_wdata_o <= sel_wdata;
            end
        end
    end

    // Stage i holds the access issued i cycles ago; writes enter as invalid.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            for (int i = 0; i <= RD_LAT; i++) begin
                tag_vld[i] <= 1'b0;
                tag_id[i]  <= '0;
            end
            ch_rvalid_o <= '0;
            ch_rdata_o  <= '0;
        end else begin
            tag_vld[0] <= any_gnt && !sel_we;
            tag_id[0]  <= gid;
            for (int i = 1; i <= RD_LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
            end
            ch_rvalid_o <= tag_vld[RD_LAT] ? (NUM_CH'(1) << tag_id[RD_LAT]) : '0;
            if (tag_vld[RD_LAT]) begin
                ch_rdata_o <= sram_rdata_i;
            end
        end
    end

    always_comb begin
        tag_any = 1'b0;
        for (int i = 0; i <= RD_LAT; i++) begin
            tag_any = tag_any | tag_vld[i];
        end
    end

    assign busy_o = wb_rst_ni && ((|ch_req_i) || tag_any);

endmodule

// File: tb/tb_ai_sram_arbiter.sv
// Bench for ai_sram_arbiter: a channel-0-priority instance (RD_LAT=1) and a
// pure round-robin instance (RD_LAT=2), both MAX_BURST=4, against a reference model.
module tb_ai_sram_arbiter;
    import ai_sram_arbiter_pkg::*;

    localparam int N    = 3;
    localparam int AW   = 8;
    localparam int DW   = 32;
    localparam int BW   = 4;
    localparam int MAXB = 4;
    localparam int LAT0 = 1;
    localparam int LAT1 = 2;

    typedef struct packed {
        int          due;
        logic [1:0]  ch;
        logic [31:0] data;
    } rd_t;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- per-instance stimulus and outputs ----------------
    logic [N-1:0]    req   [2];
    logic [N-1:0]    lock  [2];
    logic [N-1:0]    we    [2];
    logic [N*BW-1:0] be    [2];
    logic [N*AW-1:0] addr  [2];
    logic [N*DW-1:0] wdata [2];

    logic [N-1:0]    o_gnt   [2];
    logic [N-1:0]    o_rv    [2];
    logic [DW-1:0]   o_rdata [2];
    logic            o_en    [2];
    logic [BW-1:0]   o_we    [2];
    logic [AW-1:0]   o_addr  [2];
    logic [DW-1:0]   o_wdata [2];
    logic            o_busy  [2];
    logic [DW-1:0]   s_rdata [2];

    ai_sram_arbiter #(
        .NUM_CH(N), .AW(AW), .DW(DW), .RD_LAT(LAT0), .CH0_PRIO(1), .MAX_BURST(MAXB)
    ) dut_p (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .ch_req_i(req[0]), .ch_lock_i(lock[0]), .ch_we_i(we[0]), .ch_be_i(be[0]),
        .ch_addr_i(addr[0]), .ch_wdata_i(wdata[0]),
        .ch_gnt_o(o_gnt[0]), .ch_rvalid_o(o_rv[0]), .ch_rdata_o(o_rdata[0]),
        .sram_en_o(o_en[0]), .sram_we_o(o_we[0]), .sram_addr_o(o_addr[0]),
        .sram_wdata_o(o_wdata[0]), .sram_rdata_i(s_rdata[0]), .busy_o(o_busy[0])
    );

    ai_sram_arbiter #(
        .NUM_CH(N), .AW(AW), .DW(DW), .RD_LAT(LAT1), .CH0_PRIO(0), .MAX_BURST(MAXB)
    ) dut_r (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .ch_req_i(req[1]), .ch_lock_i(lock[1]), .ch_we_i(we[1]), .ch_be_i(be[1]),
        .ch_addr_i(addr[1]), .ch_wdata_i(wdata[1]),
        .ch_gnt_o(o_gnt[1]), .ch_rvalid_o(o_rv[1]), .ch_rdata_o(o_rdata[1]),
        .sram_en_o(o_en[1]), .sram_we_o(o_we[1]), .sram_addr_o(o_addr[1]),
        .sram_wdata_o(o_wdata[1]), .sram_rdata_i(s_rdata[1]), .busy_o(o_busy[1])
    );

    // ---------------- SRAM macro models ----------------
    logic [DW-1:0] sram_mem [2][256];
    logic [DW-1:0] rpipe    [2][2];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (o_en[d]) begin
                rpipe[d][0] <= sram_mem[d][o_addr[d]];
                for (int b = 0; b < BW; b++) begin
                    if (o_we[d][b]) sram_mem[d][o_addr[d]][b*8 +: 8] <= o_wdata[d][b*8 +: 8];
                end
            end
            rpipe[d][1] <= rpipe[d][0];
        end
    end
    assign s_rdata[0] = rpipe[0][0];
    assign s_rdata[1] = rpipe[1][1];

    // ---------------- reference model state ----------------
    int            checks, failures, cyc;
    int            m_ptr    [2];
    int            m_owner  [2];
    int            m_cnt    [2];
    int            m_last_g [2];
    logic          m_en     [2];
    logic [BW-1:0] m_we     [2];
    logic [AW-1:0] m_addr   [2];
    logic [DW-1:0] m_wdata  [2];
    logic [DW-1:0] ref_mem  [2][256];
    rd_t           exp_q0[$];
    rd_t           exp_q1[$];
    int            gnt_count [2][N];
    int            rv_count  [2][N];
    logic [DW-1:0] last_rd   [2][N];
    logic [N-1:0]  last_obs_gnt [2];

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s dut%0d cycle=%0d observed=%0h expected=%0h", tag, d, cyc, obs, exp);
        end
    endtask

    function automatic int model_pick(input int d);
        int g;
        int ex;
        int c;
        g  = -1;
        ex = -1;
        if (m_owner[d] >= 0 && req[d][m_owner[d]] && lock[d][m_owner[d]] && m_cnt[d] < MAXB) begin
            g = m_owner[d];
        end else begin
            if (m_owner[d] >= 0 && m_cnt[d] >= MAXB) begin
                for (int k = 0; k < N; k++) begin
                    if (k != m_owner[d] && req[d][k]) ex = m_owner[d];
                end
            end
            if (d == 0 && req[d][0] && ex != 0) begin
                g = 0;
            end else begin
                for (int i = 1; i <= N; i++) begin
                    c = (m_ptr[d] + i) % N;
                    if (g < 0 && req[d][c] && c != ex) g = c;
                end
            end
        end
        return g;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ptr[d]    = N - 1;
            m_owner[d]  = -1;
            m_cnt[d]    = 0;
            m_last_g[d] = -1;
            m_en[d]     = 1'b0;
            m_we[d]     = '0;
            m_addr[d]   = '0;
            m_wdata[d]  = '0;
        end
        exp_q0.delete();
        exp_q1.delete();
    endtask

    task automatic clear_counts();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < N; c++) begin
                gnt_count[d][c] = 0;
                rv_count[d][c]  = 0;
                last_rd[d][c]   = '0;
            end
        end
    endtask

    task automatic step_dut(input int d);
        int            g;
        logic [N-1:0]  eg;
        logic [N-1:0]  erv;
        logic          hit;
        logic          inflight;
        rd_t           e;
        e   = '0;
        hit = 1'b0;
        g   = model_pick(d);
        eg  = (g >= 0) ? (N'(1) << g) : '0;
        last_obs_gnt[d] = o_gnt[d];
        chk("gnt", d, 32'(o_gnt[d]), 32'(eg));
        chk("sram_en", d, 32'(o_en[d]), 32'(m_en[d]));
        chk("sram_we", d, 32'(o_we[d]), 32'(m_we[d]));
        if (m_en[d]) begin
            chk("sram_addr", d, 32'(o_addr[d]), 32'(m_addr[d]));
            chk("sram_wdata", d, o_wdata[d], m_wdata[d]);
        end
        if (d == 0) begin
            if (exp_q0.size() > 0 && exp_q0[0].due == cyc) begin
                e   = exp_q0.pop_front();
                hit = 1'b1;
            end
            inflight = (exp_q0.size() > 0);
        end else begin
            if (exp_q1.size() > 0 && exp_q1[0].due == cyc) begin
                e   = exp_q1.pop_front();
                hit = 1'b1;
            end
            inflight = (exp_q1.size() > 0);
        end
        erv = hit ? (N'(1) << e.ch) : '0;
        chk("rvalid", d, 32'(o_rv[d]), 32'(erv));
        if (hit) begin
            chk("rdata", d, o_rdata[d], e.data);
            rv_count[d][e.ch]++;
            last_rd[d][e.ch] = o_rdata[d];
        end
        chk("busy", d, 32'(o_busy[d]), 32'((|req[d]) || inflight));

        m_last_g[d] = g;
        if (g >= 0) begin
            gnt_count[d][g]++;
            m_cnt[d]   = (m_owner[d] == g && m_cnt[d] < MAXB) ? m_cnt[d] + 1 : 1;
            m_owner[d] = lock[d][g] ? g : -1;
            m_ptr[d]   = g;
            m_en[d]    = 1'b1;
            m_addr[d]  = addr[d][g*AW +: AW];
            m_wdata[d] = wdata[d][g*DW +: DW];
            if (we[d][g]) begin
                m_we[d] = be[d][g*BW +: BW];
                for (int b = 0; b < BW; b++) begin
                    if (m_we[d][b]) ref_mem[d][m_addr[d]][b*8 +: 8] = m_wdata[d][b*8 +: 8];
                end
            end else begin
                m_we[d] = '0;
                e.due   = cyc + ((d == 0) ? LAT0 : LAT1) + 2;
                e.ch    = 2'(g);
                e.data  = ref_mem[d][m_addr[d]];
                if (d == 0) exp_q0.push_back(e);
                else        exp_q1.push_back(e);
            end
        end else begin
            m_en[d]    = 1'b0;
            m_we[d]    = '0;
            m_owner[d] = -1;
            m_cnt[d]   = 0;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(negedge clk);
        for (int d = 0; d < 2; d++) step_dut(d);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic clr_all();
        for (int d = 0; d < 2; d++) begin
            req[d] = '0; lock[d] = '0; we[d] = '0;
            be[d] = '0; addr[d] = '0; wdata[d] = '0;
        end
    endtask

    task automatic set_ch(input int d, input int c, input bit r, input bit l, input bit w,
                          input logic [BW-1:0] b, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        req[d][c]            = r;
        lock[d][c]           = l;
        we[d][c]             = w;
        be[d][c*BW +: BW]    = b;
        addr[d][c*AW +: AW]  = a;
        wdata[d][c*DW +: DW] = wd;
    endtask

    task automatic new_txn(input int d, input int c, input bit l);
        set_ch(d, c, 1'b1, l, 1'($urandom_range(0, 1)), BW'($urandom_range(0, 15)),
               AW'($urandom_range(0, 15)), $urandom);
    endtask

    // Holds an ungranted request stable; starts a fresh one after a grant.
    task automatic drive(input int d, input int c, input bit r, input bit l);
        if (!r) req[d][c] = 1'b0;
        else if (!req[d][c] || m_last_g[d] == c) new_txn(d, c, l);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        clr_all();
        model_reset();
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk("rst_gnt", d, 32'(o_gnt[d]), 32'd0);
                chk("rst_rvalid", d, 32'(o_rv[d]), 32'd0);
                chk("rst_rdata", d, o_rdata[d], 32'd0);
                chk("rst_en", d, 32'(o_en[d]), 32'd0);
                chk("rst_we", d, 32'(o_we[d]), 32'd0);
                chk("rst_addr", d, 32'(o_addr[d]), 32'd0);
                chk("rst_wdata", d, o_wdata[d], 32'd0);
                chk("rst_busy", d, 32'(o_busy[d]), 32'd0);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        rst_n = 1'b1;
    endtask

    // ---------------- directed + random sequence ----------------
    logic [N-1:0] burst_exp [10];

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 256; i++) begin
                sram_mem[d][i] = $urandom;
                ref_mem[d][i]  = sram_mem[d][i];
            end
            sram_mem[d][8'h05] = 32'hDEADBEEF; ref_mem[d][8'h05] = 32'hDEADBEEF;
            sram_mem[d][8'h20] = 32'h11223344; ref_mem[d][8'h20] = 32'h11223344;
        end
        burst_exp = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100,
                      3'b010, 3'b010, 3'b010, 3'b010, 3'b100};
        clr_all();
        do_reset(3);

        // Single read of 0x05 from the Wishbone channel.
        clear_counts();
        for (int d = 0; d < 2; d++) set_ch(d, CH_WB, 1'b1, 1'b0, 1'b0, 4'hF, 8'h05, '0);
        cycle();
        clr_all();
        idle(5);
        for (int d = 0; d < 2; d++) begin
            chk("single_rd_count", d, 32'(rv_count[d][CH_WB]), 32'd1);
            chk("single_rd_data", d, last_rd[d][CH_WB], 32'hDEADBEEF);
        end

        // All channels request back to back.
        clear_counts();
        for (int k = 0; k < 6; k++) begin
            for (int d = 0; d < 2; d++)
                for (int c = 0; c < N; c++) drive(d, c, 1'b1, 1'b0);
            cycle();
        end
        clr_all();
        idle(5);
        chk("prio_ch0_all", 0, 32'(gnt_count[0][CH_WB]), 32'd6);
        for (int c = 0; c < N; c++) chk("rr_share", 1, 32'(gnt_count[1][c]), 32'd2);

        // Channel 0 every 4th cycle against steady mmul/mconv traffic.
        clear_counts();
        for (int k = 0; k < 12; k++) begin
            for (int d = 0; d < 2; d++) begin
                drive(d, CH_WB, (k % 4) == 0, 1'b0);
                drive(d, CH_MMUL, 1'b1, 1'b0);
                drive(d, CH_MCONV, 1'b1, 1'b0);
            end
            cycle();
        end
        clr_all();
        idle(5);
        chk("prio_ch0_every4", 0, 32'(gnt_count[0][CH_WB]), 32'd3);

        // Locked burst on mmul with mconv waiting.
        do_reset(1);
        for (int k = 0; k < 10; k++) begin
            for (int d = 0; d < 2; d++) begin
                drive(d, CH_MMUL, 1'b1, 1'b1);
                drive(d, CH_MCONV, 1'b1, 1'b0);
            end
            cycle();
            for (int d = 0; d < 2; d++) chk("burst_seq", d, 32'(last_obs_gnt[d]), 32'(burst_exp[k]));
        end
        clr_all();
        idle(5);

        // Byte-masked write then read-back on the conv channel.
        clear_counts();
        for (int d = 0; d < 2; d++) set_ch(d, CH_MCONV, 1'b1, 1'b0, 1'b1, 4'b0011, 8'h20, 32'hAABBCCDD);
        cycle();
        for (int d = 0; d < 2; d++) set_ch(d, CH_MCONV, 1'b1, 1'b0, 1'b0, 4'hF, 8'h20, '0);
        cycle();
        clr_all();
        idle(5);
        for (int d = 0; d < 2; d++) begin
            chk("byte_wr_data", d, last_rd[d][CH_MCONV], 32'h1122CCDD);
            chk("byte_wr_ch2", d, 32'(rv_count[d][CH_MCONV]), 32'd1);
            chk("byte_wr_other", d, 32'(rv_count[d][CH_WB] + rv_count[d][CH_MMUL]), 32'd0);
        end

        // Reset one cycle after a read grant; the read must vanish.
        clear_counts();
        for (int d = 0; d < 2; d++) set_ch(d, CH_WB, 1'b1, 1'b0, 1'b0, 4'hF, 8'h05, '0);
        cycle();
        do_reset(2);
        idle(5);
        for (int d = 0; d < 2; d++)
            chk("rst_no_rvalid", d, 32'(rv_count[d][CH_WB] + rv_count[d][CH_MMUL] + rv_count[d][CH_MCONV]), 32'd0);
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < N; c++) drive(d, c, 1'b1, 1'b0);
        cycle();
        for (int d = 0; d < 2; d++) chk("first_after_rst", d, 32'(last_obs_gnt[d]), 32'b001);
        clr_all();
        idle(5);

        // Randomized traffic with locks, holds and drops.
        for (int k = 0; k < 400; k++) begin
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < N; c++) begin
                    if (req[d][c] && m_last_g[d] != c)
                        drive(d, c, $urandom_range(0, 15) != 0, lock[d][c]);
                    else
                        drive(d, c, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
                end
            end
            cycle();
        end
        clr_all();
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
